// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - drives a 64:1 mux select sweep and serializes its output LSB first
module mux_scan_sequencer #(
  parameter int SEL_W      = 6,
  parameter int BIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [2**SEL_W-1:0]   load_data,
  input  logic [SEL_W:0]        load_len,
  input  logic                  abort,
  output logic [2**SEL_W-1:0]   mux_data,
  output logic [SEL_W-1:0]      mux_sel,
  input  logic                  mux_bit,
  output logic                  ser_bit,
  output logic                  ser_valid,
  output logic                  ser_last,
  output logic                  busy
);

  localparam int                DATA_W    = 2**SEL_W;
  localparam int                HOLD_W    = $clog2(BIT_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BIT_CYCLES - 1);
  localparam logic [SEL_W:0]    FULL_LEN  = (SEL_W+1)'(DATA_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [SEL_W:0]    len, len_clamped;
  logic              load_fire, capture, last_hit;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d     = state;
    load_ready  = 1'b0;
    busy        = 1'b0;
    load_fire   = 1'b0;
    capture     = 1'b0;
    last_hit    = 1'b0;
    // Zero and out-of-range lengths mean a full-width scan.
    len_clamped = ((load_len == '0) || (load_len > FULL_LEN)) ? FULL_LEN : load_len;
    case (state)
      IDLE: begin
        load_ready = !reset;
        load_fire  = load_valid;
        if (load_valid) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          capture  = 1'b1;
          last_hit = ({1'b0, mux_sel} == (len - (SEL_W+1)'(1)));
          if (last_hit) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mux_data  <= '0;
      mux_sel   <= '0;
      hold_cnt  <= '0;
      len       <= '0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      if (load_fire) begin
        mux_data <= load_data;
        len      <= len_clamped;
        mux_sel  <= '0;
        hold_cnt <= '0;
      end else if (state == SHIFT) begin
        if (abort) begin
          // A capture landing on the abort cycle is discarded.
          mux_sel  <= '0;
          hold_cnt <= '0;
        end else if (capture) begin
          ser_bit   <= mux_bit;
          ser_valid <= 1'b1;
          ser_last  <= last_hit;
          hold_cnt  <= '0;
          if (!last_hit) mux_sel <= mux_sel + SEL_W'(1);
        end else begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end
    end
  end

endmodule
